stream_demux4: RTL and testbench
================================

Name: stream_demux4

Overview:
- 1-to-4 demultiplexer with per-output holding registers and valid/ready handshakes on every port.
- A 2-bit address routes each input word to one of four output channels.
- Each channel counts its delivered words.
- Serves as the distribution end of the 4:1 select path: it splits one shared stream back into four per-channel consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- COUNT_WIDTH, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word at in_addr this cycle.
- in_addr  input  2  destination channel: {address1,address0}, 0..3.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit i = channel i holds a word.
- out_ready  input  4  bit i = channel i consumer takes the word this cycle.
- out_data0..out_data3  output  WIDTH each  channel 0..3 held word.
- count_clear  input  1  synchronous clear of all four counters.
- count0..count3  output  COUNT_WIDTH each  words accepted into channel 0..3.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. While reset is high at a rising edge: out_valid=0, out_data0..3=0, count0..3=0.
- in_ready during reset: forced 0.
- Reset mid-transfer: any pending held words are discarded with no handshake.
- in_ready (combinational): in_ready = ~reset & (~out_valid[in_addr] | out_ready[in_addr]).
  - Depends only on the addressed channel's state, never on in_valid.
  - The other channels' state does not affect it.
- Accept: accept = in_valid & in_ready, to channel a = in_addr. On that edge:
  - out_data_a <= in_data.
  - out_valid[a] <= 1.
  - count_a increments by 1, saturating at all-ones (no wrap).
- Latency: exactly 1 cycle from accept edge to out_valid[a]=1. There is no combinational path from in_data to out_data.
- Drain: out_valid[i] & out_ready[i] with no accept into channel i on the same edge → out_valid[i] <= 0.
  - out_data_i keeps its last value; it is not cleared.
- Same-channel drain and accept on one edge: out_valid[a] stays 1, out_data_a takes the new word, count_a increments. This gives full throughput of 1 word/cycle per channel.
- Channels are independent:
  - Any subset of channels may drain on the same edge that a different channel accepts.
  - A stalled channel (valid=1, ready=0) blocks only inputs addressed to it.
- Hold rule: while out_valid[i]=1 and out_ready[i]=0, out_data_i and out_valid[i] stay unchanged.
- Don't-care inputs:
  - in_valid=0 → in_addr and in_data are ignored; X on them must not corrupt state.
  - out_ready[i] is ignored when out_valid[i]=0 and channel i is not being accepted into.
- Counter clear: count_clear=1 zeroes all four counters on that edge.
  - Clear has priority over a coincident increment (result 0).
  - Clear does not touch out_valid or out_data.
- Saturation: a counter at 2^COUNT_WIDTH-1 stays there on further accepts. Accept and data routing still proceed normally.
- No internal state machine beyond the four 1-entry channel registers. Each channel is a two-state EMPTY/FULL register:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on hold, or on drain plus accept.

Test Plan:
- Reset, then for a=0..3 drive in_valid=1, in_addr=a, in_data=8'hA0+a for one cycle, all out_ready=0 → next cycle out_valid=4'b1111, out_data_a=8'hA0+a, count_a=1, in_ready=0 for every address. X on unselected inputs must not affect the result.
- Channel 2 full with out_ready[2]=0; present in_addr=2, in_data=8'h55 for 3 cycles → in_ready=0 throughout, out_data2 unchanged, count2 unchanged. Then raise out_ready[2] → word accepted that cycle, out_data2=8'h55 next cycle, count2 +1.
- Stream 8 words 8'h01..8'h08 to channel 1 with out_ready[1]=1 held → in_ready=1 every cycle. out_data1 sequence is 01..08, each exactly 1 cycle after accept. out_valid[1] drops the cycle after the last accept. count1=8.
- Same edge: drain channel 0 (out_ready=4'b0001) and accept 8'h3C to channel 3 → out_valid=4'b1000 next cycle, out_data0 retains its old value, count3 +1.
- COUNT_WIDTH=2: accept 5 words to channel 0 → count0 reads 1,2,3,3,3. Then assert count_clear together with an accept → count0=0 while out_valid[0]=1 with the new data.
- Assert reset while channels 1 and 3 are full and in_valid=1 → in_ready=0 that cycle, and after the edge out_valid=0, all data=0, all counts=0, with no accept counted.

Source files
------------

// File: rtl/stream_demux4.sv
// Purpose: 1-to-4 stream demux, one holding register and a saturating word counter per channel.
// Latency: 1 cycle from input accept to out_valid; no combinational in_data->out_data path.
// Backpressure: in_ready reflects only the addressed channel (empty, or draining this cycle).
module stream_demux4 #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_addr,
    input  logic [WIDTH-1:0]       in_data,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [WIDTH-1:0]       out_data0,
    output logic [WIDTH-1:0]       out_data1,
    output logic [WIDTH-1:0]       out_data2,
    output logic [WIDTH-1:0]       out_data3,
    input  logic                   count_clear,
    output logic [COUNT_WIDTH-1:0] count0,
    output logic [COUNT_WIDTH-1:0] count1,
    output logic [COUNT_WIDTH-1:0] count2,
    output logic [COUNT_WIDTH-1:0] count3
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t            state_q [4];
    chan_state_t            state_d [4];
    logic [WIDTH-1:0]       data_q  [4];
    logic [COUNT_WIDTH-1:0] cnt_q   [4];
    logic                   accept;
    logic [3:0]             acc;

    // Channel valid flags are just the FULL state of each holding register.
    always_comb begin
        out_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (state_q[i] == FULL);
        end
    end

    // A channel can take a word when empty or when its consumer drains it this cycle.
    assign in_ready = ~reset & (~out_valid[in_addr] | out_ready[in_addr]);
    assign accept   = in_valid & in_ready;

    // Per-channel accept decode and EMPTY/FULL next-state.
    always_comb begin
        acc = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            acc[i]     = accept & (in_addr == i[1:0]);
            if (acc[i]) begin
                state_d[i] = FULL;
            end else if (state_q[i] == FULL && out_ready[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    // Channel state, held data and saturating counters; data is kept (not cleared) on drain.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                if (acc[i]) begin
                    data_q[i] <= in_data;
                end
                if (count_clear) begin
                    cnt_q[i] <= '0;
                end else if (acc[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign count0    = cnt_q[0];
    assign count1    = cnt_q[1];
    assign count2    = cnt_q[2];
    assign count3    = cnt_q[3];

endmodule

// File: tb/tb_stream_demux4.sv
// Purpose: directed self-checking bench for stream_demux4 (8-bit counters plus a 2-bit-counter twin).
// Latency: checks outputs one cycle after each accepting edge.
// Backpressure: exercises stall, drain+accept and reset-while-full cases.
module tb_stream_demux4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_addr;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic       count_clear;
    logic [7:0] count0, count1, count2, count3;

    // Twin instance with 2-bit counters, fed the same stimulus.
    logic       in_ready_s;
    logic [3:0] out_valid_s;
    logic [7:0] out_data0_s, out_data1_s, out_data2_s, out_data3_s;
    logic [1:0] count0_s, count1_s, count2_s, count3_s;

    logic [7:0] dat [4];
    logic [7:0] cnt [4];
    assign dat[0] = out_data0;
    assign dat[1] = out_data1;
    assign dat[2] = out_data2;
    assign dat[3] = out_data3;
    assign cnt[0] = count0;
    assign cnt[1] = count1;
    assign cnt[2] = count2;
    assign cnt[3] = count3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_demux4 #(.WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .count_clear(count_clear),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3)
    );

    stream_demux4 #(.WIDTH(8), .COUNT_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data0(out_data0_s), .out_data1(out_data1_s), .out_data2(out_data2_s), .out_data3(out_data3_s),
        .count_clear(count_clear),
        .count0(count0_s), .count1(count1_s), .count2(count2_s), .count3(count3_s)
    );

    // Advance past the next rising edge; inputs change and outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_addr = 2'd0; in_data = 8'h00;
        out_ready = 4'b0000; count_clear = 1'b0;
        step();
        step();
        #3;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (dat[i] !== 8'h00) begin fails++; $display("FAIL reset_data%0d: got %h want 00", i, dat[i]); end
            tests++; if (cnt[i] !== 8'h00) begin fails++; $display("FAIL reset_count%0d: got %0d want 0", i, cnt[i]); end
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [7:0] exp_d;
        for (int a = 0; a < 4; a++) begin
            in_valid = 1'b1; in_addr = a[1:0]; in_data = 8'hA0 + 8'(a);
            #3;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b want 1", a, in_ready); end
            step();
        end
        // Idle cycle with junk on the ignored inputs must not disturb anything.
        in_valid = 1'b0; in_addr = 2'bxx; in_data = 8'hxx;
        step();
        #3;
        tests++; if (out_valid !== 4'b1111) begin fails++; $display("FAIL fill_valid: got %b want 1111", out_valid); end
        for (int a = 0; a < 4; a++) begin
            exp_d = 8'hA0 + 8'(a);
            tests++; if (dat[a] !== exp_d) begin fails++; $display("FAIL fill_data%0d: got %h want %h", a, dat[a], exp_d); end
            tests++; if (cnt[a] !== 8'd1) begin fails++; $display("FAIL fill_count%0d: got %0d want 1", a, cnt[a]); end
            in_addr = a[1:0];
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_blocked%0d: got %b want 0", a, in_ready); end
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_addr = 2'd2; in_data = 8'h55; out_ready = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #3;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready c%0d: got %b want 0", c, in_ready); end
            tests++; if (out_data2 !== 8'hA2) begin fails++; $display("FAIL stall_data c%0d: got %h want a2", c, out_data2); end
            tests++; if (count2 !== 8'd1) begin fails++; $display("FAIL stall_count c%0d: got %0d want 1", c, count2); end
            step();
        end
        out_ready = 4'b0100;
        #3;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        #3;
        tests++; if (out_data2 !== 8'h55) begin fails++; $display("FAIL stall_new_data: got %h want 55", out_data2); end
        tests++; if (count2 !== 8'd2) begin fails++; $display("FAIL stall_new_count: got %0d want 2", count2); end
        tests++; if (out_valid !== 4'b1111) begin fails++; $display("FAIL stall_valid: got %b want 1111", out_valid); end
    endtask

    task automatic test_clear();
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        #3;
        for (int a = 0; a < 4; a++) begin
            tests++; if (cnt[a] !== 8'd0) begin fails++; $display("FAIL clear_count%0d: got %0d want 0", a, cnt[a]); end
        end
        tests++; if (out_valid !== 4'b1111) begin fails++; $display("FAIL clear_valid: got %b want 1111", out_valid); end
        tests++; if (out_data2 !== 8'h55) begin fails++; $display("FAIL clear_data2: got %h want 55", out_data2); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        out_ready = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            w = 8'(k);
            in_valid = 1'b1; in_addr = 2'd1; in_data = w;
            #3;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
            step();
            in_valid = 1'b0;
            #1;
            tests++; if (out_data1 !== w || out_valid[1] !== 1'b1) begin
                fails++; $display("FAIL b2b_word%0d: got data %h valid %b want %h 1", k, out_data1, out_valid[1], w);
            end
        end
        step();
        #3;
        tests++; if (out_valid !== 4'b1101) begin fails++; $display("FAIL b2b_drain_valid: got %b want 1101", out_valid); end
        tests++; if (out_data1 !== 8'h08) begin fails++; $display("FAIL b2b_last_data: got %h want 08", out_data1); end
        tests++; if (count1 !== 8'd8) begin fails++; $display("FAIL b2b_count: got %0d want 8", count1); end
    endtask

    task automatic test_same_edge();
        out_ready = 4'b1100;
        step();
        #3;
        tests++; if (out_valid !== 4'b0001) begin fails++; $display("FAIL same_pre_valid: got %b want 0001", out_valid); end
        out_ready = 4'b0001; in_valid = 1'b1; in_addr = 2'd3; in_data = 8'h3C;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL same_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        #3;
        tests++; if (out_valid !== 4'b1000) begin fails++; $display("FAIL same_valid: got %b want 1000", out_valid); end
        tests++; if (out_data0 !== 8'hA0) begin fails++; $display("FAIL same_data0_kept: got %h want a0", out_data0); end
        tests++; if (out_data3 !== 8'h3C) begin fails++; $display("FAIL same_data3: got %h want 3c", out_data3); end
        tests++; if (count3 !== 8'd1) begin fails++; $display("FAIL same_count3: got %0d want 1", count3); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s [5];
        exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3; exp_s[4] = 2'd3;
        out_ready = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_addr = 2'd0; in_data = 8'h10 + 8'(k);
            step();
            in_valid = 1'b0;
            #1;
            tests++; if (count0_s !== exp_s[k]) begin fails++; $display("FAIL sat_count%0d: got %0d want %0d", k, count0_s, exp_s[k]); end
            tests++; if (count0 !== 8'(k + 1)) begin fails++; $display("FAIL sat_wide_count%0d: got %0d want %0d", k, count0, k + 1); end
            tests++; if (out_data0_s !== 8'h10 + 8'(k)) begin fails++; $display("FAIL sat_data%0d: got %h want %h", k, out_data0_s, 8'h10 + 8'(k)); end
        end
        in_valid = 1'b1; in_addr = 2'd0; in_data = 8'h77; count_clear = 1'b1;
        step();
        in_valid = 1'b0; count_clear = 1'b0; out_ready = 4'b0000;
        #3;
        tests++; if (count0_s !== 2'd0) begin fails++; $display("FAIL sat_clear_prio: got %0d want 0", count0_s); end
        tests++; if (count0 !== 8'd0) begin fails++; $display("FAIL sat_clear_wide: got %0d want 0", count0); end
        tests++; if (out_valid[0] !== 1'b1 || out_data0 !== 8'h77) begin
            fails++; $display("FAIL sat_clear_accept: got valid %b data %h want 1 77", out_valid[0], out_data0);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_addr = 2'd1; in_data = 8'h11;
        step();
        #3;
        tests++; if (out_valid !== 4'b1011) begin fails++; $display("FAIL rmid_pre_valid: got %b want 1011", out_valid); end
        reset = 1'b1; in_addr = 2'd2; in_data = 8'h22;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
        step();
        reset = 1'b0; in_valid = 1'b0;
        #3;
        tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL rmid_valid: got %b want 0000", out_valid); end
        for (int a = 0; a < 4; a++) begin
            tests++; if (dat[a] !== 8'h00) begin fails++; $display("FAIL rmid_data%0d: got %h want 00", a, dat[a]); end
            tests++; if (cnt[a] !== 8'd0) begin fails++; $display("FAIL rmid_count%0d: got %0d want 0", a, cnt[a]); end
        end
        step();
        #3;
        tests++; if (count2 !== 8'd0 || out_valid !== 4'b0000) begin
            fails++; $display("FAIL rmid_after: got count2 %0d valid %b want 0 0000", count2, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_clear();
        test_back_to_back();
        test_same_edge();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
